// File: rtl/sahb_mem_responder.sv
// sahb_mem_responder: simple-AHB single-port word memory responder with wait states,
// a fast path for sequential burst beats and an optional out-of-range error response.
// Params: ADDR_W, DATA_W, DEPTH_LOG2, WAIT_STATES (0..15), BASE_ADDR.
// Ports : clk, rst (async, active-high); haddr, hwrite[NB], hburst, htrans, hwdata in;
//         hready (1-cycle pulse), hresp, hrdata (registered) out.
// Macro : SAHB_RESP_ERR_EN enables the two-cycle error response for out-of-range
//         addresses; when undefined the upper address bits alias and hresp is 0.
module sahb_mem_responder #(
  parameter int                ADDR_W      = 24,
  parameter int                DATA_W      = 16,
  parameter int                DEPTH_LOG2  = 12,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   haddr,
  input  logic [DATA_W/8-1:0] hwrite,
  input  logic                hburst,
  input  logic                htrans,
  input  logic [DATA_W-1:0]   hwdata,
  output logic                hready,
  output logic                hresp,
  output logic [DATA_W-1:0]   hrdata
);

  localparam int NB   = DATA_W / 8;
  localparam int OFF  = $clog2(NB);
  localparam int IDXW = DEPTH_LOG2;
  localparam int LO   = DEPTH_LOG2 + OFF;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
`ifdef SAHB_RESP_ERR_EN
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;
`endif

  logic [DATA_W-1:0] mem [2**IDXW];

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [NB-1:0]     wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bcur_q, bcur_d;
  logic              pburst_q, pburst_d;
  logic [IDXW-1:0]   lidx_q, lidx_d;
  logic              hready_q, hready_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;

  logic [IDXW-1:0]   idx_in;
  logic [IDXW:0]     nxt_idx;
  logic [IDXW-1:0]   rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              in_range;
  logic              fast;
  logic              unused_bits;

  assign idx_in = haddr[LO-1:OFF];

`ifdef SAHB_RESP_ERR_EN
  logic hresp_q, hresp_d;
  assign in_range    = (haddr[ADDR_W-1:LO] == BASE_ADDR[ADDR_W-1:LO]);
  assign unused_bits = ^haddr[OFF-1:0];
  assign hresp       = hresp_q;
`else
  assign in_range    = 1'b1;
  assign unused_bits = ^{haddr[ADDR_W-1:LO], haddr[OFF-1:0]};
  assign hresp       = 1'b0;
`endif

  // Widened increment so the top-index -> 0 wrap never matches.
  assign nxt_idx = {1'b0, lidx_q} + (IDXW+1)'(1);
  assign fast    = pburst_q & hburst & (nxt_idx == {1'b0, idx_in});

  // The fast path reads straight from the live address.
  assign rd_idx  = (state_q == S_IDLE) ? idx_in : idx_q;
  assign rd_word = mem[rd_idx];

  assign hready = hready_q;
  assign hrdata = hrdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    bcur_d   = bcur_q;
    pburst_d = pburst_q;
    lidx_d   = lidx_q;
    hready_d = 1'b0;
    hrdata_d = hrdata_q;
`ifdef SAHB_RESP_ERR_EN
    hresp_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (htrans) begin
          idx_d   = idx_in;
          wen_d   = hwrite;
          wdata_d = hwdata;
          bcur_d  = hburst;
          if (!in_range) begin
`ifdef SAHB_RESP_ERR_EN
            state_d  = S_ERR1;
            hresp_d  = 1'b1;
            pburst_d = 1'b0;
`endif
          end else if (fast) begin
            state_d  = S_RESP;
            hready_d = 1'b1;
            if (hwrite == '0) hrdata_d = rd_word;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RESP;
          hready_d = 1'b1;
          if (wen_q == '0) hrdata_d = rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d  = S_IDLE;
        pburst_d = bcur_q;
        lidx_d   = idx_q;
      end
`ifdef SAHB_RESP_ERR_EN
      S_ERR1: begin
        state_d  = S_ERR2;
        hready_d = 1'b1;
        hresp_d  = 1'b1;
      end
      S_ERR2: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wen_q    <= '0;
      wdata_q  <= '0;
      bcur_q   <= 1'b0;
      pburst_q <= 1'b0;
      lidx_q   <= '0;
      hready_q <= 1'b0;
      hrdata_q <= '0;
`ifdef SAHB_RESP_ERR_EN
      hresp_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      bcur_q   <= bcur_d;
      pburst_q <= pburst_d;
      lidx_q   <= lidx_d;
      hready_q <= hready_d;
      hrdata_q <= hrdata_d;
`ifdef SAHB_RESP_ERR_EN
      hresp_q  <= hresp_d;
`endif
    end
  end

  // Storage is not reset; a write in flight when rst rises is dropped.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RESP) begin
      for (int i = 0; i < NB; i++) begin
        if (wen_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sahb_mem_responder.sv
// tb_sahb_mem_responder: self-checking bench for sahb_mem_responder.
// Vector table of transfers with latency/response/data expectations, plus reset and error sequences.
module tb_sahb_mem_responder;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int DL = 12;
  localparam int WS = 1;
  localparam int L  = WS + 2;
  localparam int F  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] haddr = '0;
  logic [1:0]    hwrite = '0;
  logic          hburst = 1'b0;
  logic          htrans = 1'b0;
  logic [DW-1:0] hwdata = '0;
  logic          hready;
  logic          hresp;
  logic [DW-1:0] hrdata;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] last_rd = '0;

  typedef struct {
    logic [AW-1:0] a;
    logic [1:0]    w;
    logic [DW-1:0] d;
    logic          b;
    int            lat;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tv[$];

  sahb_mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL),
    .WAIT_STATES(WS), .BASE_ADDR('0)
  ) dut (
    .clk(clk), .rst(rst), .haddr(haddr), .hwrite(hwrite),
    .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts in IDLE at #1 after an edge; ends back in IDLE at #1 after an edge.
  task automatic xfer(input logic [AW-1:0] a, input logic [1:0] w, input logic [DW-1:0] d,
                      input logic b, input int exp_lat, input logic exp_err,
                      input logic [DW-1:0] exp_rd, input string tag);
    int n;
    logic done;
    logic early;
    logic [DW-1:0] e;
    haddr = a; hwrite = w; hwdata = d; hburst = b; htrans = 1'b1;
    if (w == 2'b00) sb_q.push_back(exp_rd);
    n = 0; done = 1'b0; early = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (hready) done = 1'b1;
      else if (hresp) early = 1'b1;
    end
    htrans = 1'b0; hwrite = '0; hburst = 1'b0;
    if (!done) begin
      checks++; fails++;
      $display("FAIL %s timeout: no hready after %0d cycles, required %0d", tag, n, exp_lat);
      if (w == 2'b00) void'(sb_q.pop_back());
    end else begin
      check({tag, " latency"}, n, exp_lat);
      check({tag, " hresp"}, {31'b0, hresp}, {31'b0, exp_err});
      if (exp_err) check({tag, " err1"}, {31'b0, early}, 32'd1);
      if (w == 2'b00) begin
        e = sb_q.pop_front();
        check({tag, " rdata"}, {16'b0, hrdata}, {16'b0, e});
        last_rd = e;
      end else begin
        check({tag, " hold"}, {16'b0, hrdata}, {16'b0, last_rd});
      end
    end
    @(posedge clk); #1;
    check({tag, " pulse"}, {30'b0, hready, hresp}, 32'd0);
  endtask

  initial begin
    tv.push_back('{24'h000010, 2'b11, 16'hBEEF, 1'b0, L, 16'h0000});
    tv.push_back('{24'h000010, 2'b00, 16'h0000, 1'b0, L, 16'hBEEF});
    tv.push_back('{24'h000010, 2'b10, 16'h1234, 1'b0, L, 16'h0000});
    tv.push_back('{24'h000010, 2'b00, 16'h0000, 1'b0, L, 16'h12EF});
    tv.push_back('{24'h000011, 2'b01, 16'h00AB, 1'b0, L, 16'h0000});
    tv.push_back('{24'h000010, 2'b00, 16'h0000, 1'b0, L, 16'h12AB});
    tv.push_back('{24'h000020, 2'b11, 16'h5A01, 1'b0, L, 16'h0000});
    tv.push_back('{24'h000022, 2'b11, 16'h5A02, 1'b0, L, 16'h0000});
    tv.push_back('{24'h000024, 2'b11, 16'h5A03, 1'b0, L, 16'h0000});
    tv.push_back('{24'h000030, 2'b11, 16'h5A04, 1'b0, L, 16'h0000});
    tv.push_back('{24'h000020, 2'b00, 16'h0000, 1'b1, L, 16'h5A01});
    tv.push_back('{24'h000022, 2'b00, 16'h0000, 1'b1, F, 16'h5A02});
    tv.push_back('{24'h000024, 2'b00, 16'h0000, 1'b1, F, 16'h5A03});
    tv.push_back('{24'h000030, 2'b00, 16'h0000, 1'b1, L, 16'h5A04});
    tv.push_back('{24'h000022, 2'b00, 16'h0000, 1'b0, L, 16'h5A02});
    tv.push_back('{24'h000024, 2'b00, 16'h0000, 1'b1, L, 16'h5A03});
    tv.push_back('{24'h001FFE, 2'b11, 16'h7777, 1'b0, L, 16'h0000});
    tv.push_back('{24'h000000, 2'b11, 16'h0001, 1'b0, L, 16'h0000});
    tv.push_back('{24'h000002, 2'b11, 16'h0002, 1'b0, L, 16'h0000});
    tv.push_back('{24'h001FFE, 2'b00, 16'h0000, 1'b1, L, 16'h7777});
    tv.push_back('{24'h000000, 2'b00, 16'h0000, 1'b1, L, 16'h0001});
    tv.push_back('{24'h000002, 2'b00, 16'h0000, 1'b1, F, 16'h0002});
    tv.push_back('{24'h000040, 2'b11, 16'h5555, 1'b0, L, 16'h0000});

    repeat (3) @(posedge clk);
    #1;
    check("reset hready", {31'b0, hready}, 32'd0);
    check("reset hresp", {31'b0, hresp}, 32'd0);
    check("reset hrdata", {16'b0, hrdata}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      xfer(tv[i].a, tv[i].w, tv[i].d, tv[i].b, tv[i].lat, 1'b0, tv[i].rd,
           $sformatf("vec%0d", i));
    end

`ifdef SAHB_RESP_ERR_EN
    xfer(24'h800000, 2'b11, 16'hDEAD, 1'b0, 2, 1'b1, 16'h0000, "oor write");
    xfer(24'h000000, 2'b00, 16'h0000, 1'b0, L, 1'b0, 16'h0001, "oor unchanged");
`else
    xfer(24'h800000, 2'b11, 16'hDEAD, 1'b0, L, 1'b0, 16'h0000, "alias write");
    xfer(24'h000000, 2'b00, 16'h0000, 1'b0, L, 1'b0, 16'hDEAD, "alias read");
`endif

    haddr = 24'h000040; hwrite = 2'b11; hwdata = 16'hAAAA; hburst = 1'b0;
    htrans = 1'b1;
    @(posedge clk); #1;
    check("wait hready", {31'b0, hready}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst hready", {31'b0, hready}, 32'd0);
    check("rst hresp", {31'b0, hresp}, 32'd0);
    check("rst hrdata", {16'b0, hrdata}, 32'd0);
    htrans = 1'b0; hwrite = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_rd = '0;
    xfer(24'h000040, 2'b00, 16'h0000, 1'b0, L, 1'b0, 16'h5555, "rst abandon");

    check("sb empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sahb_mem_responder.md
SAHB_MEM_RESPONDER -- requirements
Module: sahb_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 24: bus address width in bits.
REQ-002 Parameter DATA_W, default 16: data width; byte lanes NB = DATA_W/8.
REQ-003 Parameter DEPTH_LOG2, default 12: log2 of the number of DATA_W words stored.
REQ-004 Parameter WAIT_STATES, default 1, range 0..15: extra cycles inserted before each non-fast response.
REQ-005 Parameter BASE_ADDR, default 0: byte base address, aligned to the region size.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 haddr  input  ADDR_W  byte address of the transfer.
REQ-009 hwrite  input  NB  byte-lane write enables; all-zero means read.
REQ-010 hburst  input  1  the current beat is part of an incrementing burst.
REQ-011 htrans  input  1  transfer request; the initiator holds it and all inputs stable until hready.
REQ-012 hwdata  input  DATA_W  write data, lane i = bits 8i+7:8i.
REQ-013 hready  output  1  one-cycle pulse marking transfer completion.
REQ-014 hresp  output  1  error flag, meaningful with hready.
REQ-015 hrdata  output  DATA_W  registered read data, valid in the hready cycle of a read.

Function
REQ-016 Word index SHALL be haddr[DEPTH_LOG2:1] (DATA_W=16); byte offset bits SHALL be ignored; lanes are selected by hwrite only.
REQ-017 In-range SHALL mean haddr[ADDR_W-1:DEPTH_LOG2+1] equals the same bits of BASE_ADDR.
REQ-018 The FSM SHALL have states IDLE, WAIT, RESP and ERR1/ERR2.
REQ-019 htrans SHALL be sampled only in IDLE.
- On htrans=1 in IDLE, haddr, hwrite, hwdata and hburst SHALL be latched.
- Changes to htrans outside IDLE SHALL be ignored.
REQ-020 IDLE, htrans=1, in range, not fast: go to WAIT with counter=WAIT_STATES.
REQ-021 WAIT: if counter==0, go to RESP; else decrement the counter.
REQ-022 RESP SHALL last exactly one cycle with hready=1, hresp=0, then go to IDLE.
- Write: enabled lanes of the latched word SHALL be committed at the RESP clock edge.
- Read: hrdata SHALL present the stored word during RESP.
REQ-023 Single-beat latency SHALL be hready at WAIT_STATES+2 cycles after the IDLE sample edge; with WAIT_STATES=0, hready SHALL occur at +2.
REQ-024 Fast burst: if the previous completed beat had hburst=1, the new request has hburst=1, and the new word index equals the previous index+1, IDLE SHALL go directly to RESP with hready at +1.
- Index wrap-around at 2^DEPTH_LOG2-1 -> 0 SHALL NOT qualify as fast.
REQ-025 The burst-tracking flag SHALL be cleared by any non-burst beat, any error, and reset.
REQ-026 hrdata SHALL update only on read responses and hold its value otherwise.
REQ-027 Back-to-back transfers SHALL incur one IDLE cycle between hready and the next sample.
REQ-028 A read immediately following a write to the same word SHALL return the newly written data.

Reset
REQ-029 rst SHALL force: state=IDLE, hready=0, hresp=0, hrdata=0, counter=0, burst flag=0.
REQ-030 A transfer interrupted by rst SHALL be abandoned with no write committed; memory contents are undefined after power-up and SHALL be unchanged by reset.
REQ-031 The first htrans sample SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro SAHB_RESP_ERR_EN:
- Defined: an out-of-range request in IDLE SHALL go to ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), then IDLE; no memory access SHALL occur.
- Undefined: address upper bits SHALL be ignored (aliasing); ERR states SHALL be absent; hresp SHALL be tied 0.

Verification
REQ-033 WAIT_STATES=1, write haddr=0x000010, hwrite=2'b11, hwdata=0xBEEF -> hready at cycle +3, hresp=0; a following read of 0x000010 -> hrdata=0xBEEF.
REQ-034 Lane write hwrite=2'b10, hwdata=0x1234 onto word 0xBEEF -> readback 0x12EF.
REQ-035 Burst reads 0x20, 0x22, 0x24 with hburst=1 -> first hready at +3, later beats at +1 each; a burst jump to 0x30 -> +3.
REQ-036 With SAHB_RESP_ERR_EN, access 0x800000 -> hresp=1 for two cycles, hready=1 in the second only, memory unchanged; without the macro -> aliases to word 0, hresp=0.
REQ-037 rst pulse during WAIT of a write of 0xAAAA to 0x40 -> outputs zero, IDLE; readback of 0x40 differs from 0xAAAA (pre-seeded 0x5555 returns 0x5555).
REQ-038 Word 2^DEPTH_LOG2-1 burst beat followed by word 0 with hburst=1 -> no fast path (hready at +WAIT_STATES+2).
